ddr3_master_wr_mover: RTL and testbench
=======================================

Name: ddr3_master_wr_mover

Overview:
- Downstream stage of the MJPEG-to-DPB packer.
- Takes each "rank ready" request (rank, 128-bit beat count, tail byte count, frame-end flag), reads that rank out of DPB port B as 64-bit word pairs and issues 128-bit write commands to the DDR3 controller user interface.
- Frames land in two ping-pong DDR3 regions. Per-frame byte length and a done pulse are reported to the UDP read side.

Parameters:
- DPB_RD_LAT, 2: cycles from DPB port-B address to valid o_dpb_rd_b_rd_data (output register enabled).
- FRAME0_BASE, 28'h0000000: DDR3 app address of frame slot 0.
- FRAME1_BASE, 28'h0400000: DDR3 app address of frame slot 1.
- ADDR_STEP, 8: app_addr increment per 128-bit beat (BL8 on x16).
- REQ_FIFO_DEPTH, 4: pending-request queue depth (power of 2).

Ports:
- i_pclk in 1: clock; DPB port B and DDR3 UI share it.
- i_rst in 1: reset, synchronous, active-high.
- i_wr_req in 1: one-cycle rank-ready pulse from the packer.
- i_wr_frame_down in 1: qualifies i_wr_req; this rank ends the frame.
- i_wr_buf_rank in 2: rank holding the data.
- i_wr_buf_128cnt in 7: number of 128-bit beats in the rank (0..91).
- i_wr_buf_Bytecnt in 6: valid bytes in the last beat; 0 means the last beat is full.
- o_dpb_rd_b_addr out 10: {rank, word index}.
- o_dpb_rd_b_cea out 1: port-B clock enable, tied 1.
- i_dpb_rd_b_rd_data in 64: port-B read data.
- o_app_cmd out 3: DDR3 command, always 3'b000 (write).
- o_app_cmd_en out 1: command valid.
- o_app_addr out 28: DDR3 command address.
- o_app_wdf_data out 128: write data.
- o_app_wdf_wren out 1: write data valid.
- o_app_wdf_end out 1: last word of burst; equals o_app_wdf_wren.
- i_app_rdy in 1: controller accepts the command.
- i_app_wdf_rdy in 1: controller accepts the write data.
- i_init_calib_complete in 1: DDR3 is ready.
- o_frame_done out 1: one-cycle pulse when a frame is fully written.
- o_frame_slot out 1: slot of the just-finished frame; valid with o_frame_done.
- o_frame_len out 24: byte length of the just-finished frame; valid with o_frame_done and held until the next pulse.
- o_busy out 1: high whenever the FSM is not in IDLE or the queue is non-empty.
- o_overflow out 1: sticky; a request arrived while the queue was full.

Behaviour:
- Reset values:
  - All outputs 0, except o_dpb_rd_b_cea = 1.
  - Queue empty, write slot = 0, o_app_addr = FRAME0_BASE, frame-length accumulator = 0.
  - Reset in any state aborts the in-flight beat and flushes the queue, with no frame_done.
- Request queue:
  - On i_wr_req, push {rank, 128cnt, Bytecnt, frame_down}.
  - If the queue is full, drop the request and set o_overflow. Only i_rst clears o_overflow.
  - A push and a pop in the same cycle are both honoured.
- FSM states: IDLE, POP, RD_HI, RD_LO, WAIT_DATA, ISSUE, NEXT, FRAME_END.
- IDLE:
  - Go to POP when the queue is non-empty and i_init_calib_complete = 1.
  - Before calibration, requests queue but are not served.
- POP:
  - Latch the head entry and set beat index k = 0.
  - If 128cnt = 0, go to NEXT. Otherwise go to RD_HI.
- RD_HI: o_dpb_rd_b_addr = {rank, 2k}.
- RD_LO: o_dpb_rd_b_addr = {rank, 2k+1}.
- WAIT_DATA:
  - Capture the even word into o_app_wdf_data[127:64] and the odd word into [63:0], each DPB_RD_LAT cycles after its address.
  - Go to ISSUE once both words are captured.
- ISSUE:
  - Drive o_app_cmd_en = o_app_wdf_wren = o_app_wdf_end = 1, with o_app_addr at the current address.
  - Hold all three until a cycle in which i_app_rdy and i_app_wdf_rdy are both 1. The beat completes in that cycle.
  - Deassert all three the next cycle.
  - Add ADDR_STEP to the address, modulo 2^28.
  - Increment k. If k < 128cnt, go to RD_HI; otherwise go to NEXT.
- NEXT:
  - Add the packet bytes to the accumulator (24-bit wrap):
    - 0 if 128cnt = 0;
    - 128cnt*16 if Bytecnt = 0;
    - otherwise (128cnt-1)*16 + Bytecnt.
  - If frame_down, go to FRAME_END; else go to IDLE.
- FRAME_END:
  - Set o_frame_len to the total, o_frame_slot to the current slot, and pulse o_frame_done for 1 cycle.
  - Toggle the slot, load the address with the new slot's base, clear the accumulator, go to IDLE.
- Ordering: ranks are written strictly in request order; no beat of one rank interleaves with another.
- Timing: minimum per beat is 3 (RD_HI, RD_LO, ISSUE) + DPB_RD_LAT cycles when the DDR3 is always ready.

Test Plan:
- Single full rank:
  - Stimulus: req with rank 1, 128cnt 91, Bytecnt 0, frame_down 0, after calib.
  - Response: 91 write commands at FRAME0_BASE + 8k; data[127:64] = DPB word {1, 2k}, data[63:0] = DPB word {1, 2k+1}; no frame_done.
- Frame end with tail:
  - Stimulus: full rank, then req with 128cnt 5, Bytecnt 3, frame_down 1.
  - Response: 96 beats total; o_frame_done pulses once with o_frame_len = 1456 + 67 = 1523 and slot 0; the next frame starts at FRAME1_BASE.
- Backpressure:
  - Stimulus: hold i_app_wdf_rdy low for 10 cycles during beat 2.
  - Response: cmd_en/wren stay high and stable for those cycles; exactly 1 acceptance; the address advances once.
- Queue overflow:
  - Stimulus: 5 requests with calib low.
  - Response: o_overflow = 1; after calib rises, only the first 4 are written, in order.
- Empty frame end:
  - Stimulus: req with 128cnt 0, frame_down 1.
  - Response: no DDR3 command; o_frame_done pulses with o_frame_len equal to the prior accumulator total.
- Reset mid-beat:
  - Stimulus: assert i_rst while in ISSUE.
  - Response: next cycle cmd_en/wren are 0, the queue is empty, o_app_addr = FRAME0_BASE, and no frame_done.

Source files
------------

// File: rtl/ddr3_master_wr_mover.sv
// Drains packed DPB ranks into DDR3 as 128-bit write bursts, ping-ponging whole frames
// between two DDR3 regions and reporting each finished frame's byte length.
module ddr3_master_wr_mover #(
    parameter int          DPB_RD_LAT     = 2,
    parameter logic [27:0] FRAME0_BASE    = 28'h0000000,
    parameter logic [27:0] FRAME1_BASE    = 28'h0400000,
    parameter logic [27:0] ADDR_STEP      = 28'd8,
    parameter int          REQ_FIFO_DEPTH = 4
) (
    input  logic         i_pclk,
    input  logic         i_rst,
    input  logic         i_wr_req,
    input  logic         i_wr_frame_down,
    input  logic [1:0]   i_wr_buf_rank,
    input  logic [6:0]   i_wr_buf_128cnt,
    input  logic [5:0]   i_wr_buf_Bytecnt,
    output logic [9:0]   o_dpb_rd_b_addr,
    output logic         o_dpb_rd_b_cea,
    input  logic [63:0]  i_dpb_rd_b_rd_data,
    output logic [2:0]   o_app_cmd,
    output logic         o_app_cmd_en,
    output logic [27:0]  o_app_addr,
    output logic [127:0] o_app_wdf_data,
    output logic         o_app_wdf_wren,
    output logic         o_app_wdf_end,
    input  logic         i_app_rdy,
    input  logic         i_app_wdf_rdy,
    input  logic         i_init_calib_complete,
    output logic         o_frame_done,
    output logic         o_frame_slot,
    output logic [23:0]  o_frame_len,
    output logic         o_busy,
    output logic         o_overflow
);
    localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);

    typedef struct packed {
        logic [1:0] rank;
        logic [6:0] cnt;
        logic [5:0] bytes;
        logic       frame_down;
    } req_t;

    typedef enum logic [2:0] {
        IDLE, POP, RD_HI, RD_LO, WAIT_DATA, ISSUE, NEXT, FRAME_END
    } state_t;

    req_t               fifo_mem [REQ_FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_reg, rd_ptr_reg;
    logic               fifo_empty, fifo_full, push, pop;
    req_t               head, cur_reg;

    state_t             state_reg;
    logic [6:0]         k_reg, k_inc;
    logic [9:0]         dpb_addr_reg;
    logic [127:0]       wdf_data_reg;
    logic               cmd_en_reg;
    logic [27:0]        app_addr_reg;
    logic               slot_reg;
    logic [23:0]        acc_reg;
    logic               frame_done_reg, frame_slot_reg, overflow_reg;
    logic [23:0]        frame_len_reg;
    logic [10:0]        pkt_bytes;
    logic [DPB_RD_LAT-1:0] hi_pipe_reg, lo_pipe_reg, hi_pipe_next, lo_pipe_next;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign push       = i_wr_req && !fifo_full;
    assign pop        = (state_reg == POP);
    assign head       = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    assign k_inc      = k_reg + 7'd1;

    always_ff @(posedge i_pclk) begin
        if (push)
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= '{rank: i_wr_buf_rank, cnt: i_wr_buf_128cnt,
                                                bytes: i_wr_buf_Bytecnt, frame_down: i_wr_frame_down};
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (i_wr_req && fifo_full)
                overflow_reg <= 1'b1;
        end
    end

    // Valid tokens follow each port-B address down the read latency so the
    // matching data word is captured exactly when it appears.
    genvar gi;
    generate
        for (gi = 0; gi < DPB_RD_LAT; gi++) begin : g_rd_pipe
            if (gi == 0) begin : g_first
                assign hi_pipe_next[gi] = (state_reg == RD_HI);
                assign lo_pipe_next[gi] = (state_reg == RD_LO);
            end else begin : g_rest
                assign hi_pipe_next[gi] = hi_pipe_reg[gi-1];
                assign lo_pipe_next[gi] = lo_pipe_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            hi_pipe_reg <= '0;
            lo_pipe_reg <= '0;
        end else begin
            hi_pipe_reg <= hi_pipe_next;
            lo_pipe_reg <= lo_pipe_next;
        end
    end

    // Bytes contributed by one rank; a zero tail count means the last beat is full.
    always_comb begin
        pkt_bytes = '0;
        if (cur_reg.cnt != 7'd0) begin
            if (cur_reg.bytes == 6'd0)
                pkt_bytes = {cur_reg.cnt, 4'b0000};
            else
                pkt_bytes = {cur_reg.cnt - 7'd1, 4'b0000} + 11'(cur_reg.bytes);
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            cur_reg        <= '0;
            k_reg          <= '0;
            dpb_addr_reg   <= '0;
            wdf_data_reg   <= '0;
            cmd_en_reg     <= 1'b0;
            app_addr_reg   <= FRAME0_BASE;
            slot_reg       <= 1'b0;
            acc_reg        <= '0;
            frame_done_reg <= 1'b0;
            frame_slot_reg <= 1'b0;
            frame_len_reg  <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            if (hi_pipe_reg[DPB_RD_LAT-1])
                wdf_data_reg[127:64] <= i_dpb_rd_b_rd_data;
            if (lo_pipe_reg[DPB_RD_LAT-1])
                wdf_data_reg[63:0] <= i_dpb_rd_b_rd_data;

            case (state_reg)
                IDLE: begin
                    if (!fifo_empty && i_init_calib_complete)
                        state_reg <= POP;
                end
                POP: begin
                    cur_reg <= head;
                    k_reg   <= '0;
                    if (head.cnt == 7'd0) begin
                        state_reg <= NEXT;
                    end else begin
                        dpb_addr_reg <= {head.rank, 8'd0};
                        state_reg    <= RD_HI;
                    end
                end
                RD_HI: begin
                    dpb_addr_reg <= {cur_reg.rank, k_reg, 1'b1};
                    state_reg    <= RD_LO;
                end
                RD_LO: state_reg <= WAIT_DATA;
                WAIT_DATA: begin
                    if (lo_pipe_reg[DPB_RD_LAT-1]) begin
                        cmd_en_reg <= 1'b1;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_app_rdy && i_app_wdf_rdy) begin
                        cmd_en_reg   <= 1'b0;
                        app_addr_reg <= app_addr_reg + ADDR_STEP;
                        k_reg        <= k_inc;
                        if (k_inc < cur_reg.cnt) begin
                            dpb_addr_reg <= {cur_reg.rank, k_inc, 1'b0};
                            state_reg    <= RD_HI;
                        end else begin
                            state_reg <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    acc_reg   <= acc_reg + 24'(pkt_bytes);
                    state_reg <= cur_reg.frame_down ? FRAME_END : IDLE;
                end
                FRAME_END: begin
                    frame_len_reg  <= acc_reg;
                    frame_slot_reg <= slot_reg;
                    frame_done_reg <= 1'b1;
                    slot_reg       <= ~slot_reg;
                    app_addr_reg   <= slot_reg ? FRAME0_BASE : FRAME1_BASE;
                    acc_reg        <= '0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_dpb_rd_b_addr = dpb_addr_reg;
    assign o_dpb_rd_b_cea  = 1'b1;
    assign o_app_cmd       = 3'b000;
    assign o_app_cmd_en    = cmd_en_reg;
    assign o_app_wdf_wren  = cmd_en_reg;
    assign o_app_wdf_end   = cmd_en_reg;
    assign o_app_addr      = app_addr_reg;
    assign o_app_wdf_data  = wdf_data_reg;
    assign o_frame_done    = frame_done_reg;
    assign o_frame_slot    = frame_slot_reg;
    assign o_frame_len     = frame_len_reg;
    assign o_busy          = (state_reg != IDLE) || !fifo_empty;
    assign o_overflow      = overflow_reg;
endmodule

// File: tb/tb_ddr3_master_wr_mover.sv
// Bench for ddr3_master_wr_mover: directed and randomized rank requests checked against
// a frame/beat scoreboard derived from the request fields and a DPB memory image.
module tb_ddr3_master_wr_mover;
    localparam logic [27:0] F0 = 28'h0000000;
    localparam logic [27:0] F1 = 28'h0400000;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_wr_req = 1'b0, i_wr_frame_down = 1'b0;
    logic [1:0]   i_wr_buf_rank = '0;
    logic [6:0]   i_wr_buf_128cnt = '0;
    logic [5:0]   i_wr_buf_Bytecnt = '0;
    logic [9:0]   o_dpb_rd_b_addr;
    logic         o_dpb_rd_b_cea;
    logic [63:0]  i_dpb_rd_b_rd_data = '0;
    logic [2:0]   o_app_cmd;
    logic         o_app_cmd_en;
    logic [27:0]  o_app_addr;
    logic [127:0] o_app_wdf_data;
    logic         o_app_wdf_wren, o_app_wdf_end;
    logic         i_app_rdy = 1'b1, i_app_wdf_rdy = 1'b1;
    logic         i_init_calib_complete = 1'b0;
    logic         o_frame_done, o_frame_slot;
    logic [23:0]  o_frame_len;
    logic         o_busy, o_overflow;

    ddr3_master_wr_mover dut (
        .i_pclk(clk), .i_rst(i_rst), .i_wr_req(i_wr_req), .i_wr_frame_down(i_wr_frame_down),
        .i_wr_buf_rank(i_wr_buf_rank), .i_wr_buf_128cnt(i_wr_buf_128cnt),
        .i_wr_buf_Bytecnt(i_wr_buf_Bytecnt), .o_dpb_rd_b_addr(o_dpb_rd_b_addr),
        .o_dpb_rd_b_cea(o_dpb_rd_b_cea), .i_dpb_rd_b_rd_data(i_dpb_rd_b_rd_data),
        .o_app_cmd(o_app_cmd), .o_app_cmd_en(o_app_cmd_en), .o_app_addr(o_app_addr),
        .o_app_wdf_data(o_app_wdf_data), .o_app_wdf_wren(o_app_wdf_wren),
        .o_app_wdf_end(o_app_wdf_end), .i_app_rdy(i_app_rdy), .i_app_wdf_rdy(i_app_wdf_rdy),
        .i_init_calib_complete(i_init_calib_complete), .o_frame_done(o_frame_done),
        .o_frame_slot(o_frame_slot), .o_frame_len(o_frame_len), .o_busy(o_busy),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    // DPB port B with its output register: two cycles from address to data.
    logic [63:0] mem [1024];
    logic [63:0] dpb_d1 = '0;
    always @(posedge clk) begin
        dpb_d1             <= mem[o_dpb_rd_b_addr];
        i_dpb_rd_b_rd_data <= dpb_d1;
    end

    int checks = 0, failures = 0, cycle = 0, accepts = 0;
    bit bp_rand = 1'b0;
    int acc_times [$];
    logic [27:0]  exp_addr_q [$];
    logic [127:0] exp_data_q [$];
    logic [23:0]  exp_len_q  [$];
    logic         exp_slot_q [$];
    logic [27:0]  m_addr = F0;
    logic         m_slot = 1'b0;
    logic [23:0]  m_acc  = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_addr_q.delete(); exp_data_q.delete(); exp_len_q.delete(); exp_slot_q.delete();
        m_addr = F0; m_slot = 1'b0; m_acc = '0;
    endtask

    task automatic model_add(input logic [1:0] rank, input int cnt, input int byt, input bit fd);
        int bytes;
        for (int k = 0; k < cnt; k++) begin
            exp_addr_q.push_back(m_addr);
            exp_data_q.push_back({mem[rank * 256 + 2 * k], mem[rank * 256 + 2 * k + 1]});
            m_addr = m_addr + 28'd8;
        end
        bytes = (cnt == 0) ? 0 : (byt == 0) ? cnt * 16 : (cnt - 1) * 16 + byt;
        m_acc = m_acc + 24'(bytes);
        if (fd) begin
            exp_len_q.push_back(m_acc);
            exp_slot_q.push_back(m_slot);
            m_slot = ~m_slot;
            m_addr = m_slot ? F1 : F0;
            m_acc  = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (o_app_cmd_en && i_app_rdy && i_app_wdf_rdy) begin
            accepts++;
            acc_times.push_back(cycle);
            chk("cmd_wren_end", {o_app_cmd_en, o_app_wdf_wren, o_app_wdf_end, o_app_cmd}, 6'b111000);
            if (exp_addr_q.size() == 0)
                chk("unexpected_beat", o_app_cmd_en, 1'b0);
            else begin
                chk("beat_addr", o_app_addr, exp_addr_q.pop_front());
                chk("beat_data", o_app_wdf_data, exp_data_q.pop_front());
            end
        end
        if (o_frame_done) begin
            if (exp_len_q.size() == 0)
                chk("unexpected_frame_done", o_frame_done, 1'b0);
            else begin
                chk("frame_len", o_frame_len, exp_len_q.pop_front());
                chk("frame_slot", o_frame_slot, exp_slot_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (bp_rand) begin
            i_app_rdy     = ($urandom_range(0, 3) != 0);
            i_app_wdf_rdy = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic push_req(input logic [1:0] rank, input int cnt, input int byt, input bit fd,
                            input bit modeled);
        i_wr_req = 1'b1; i_wr_buf_rank = rank; i_wr_buf_128cnt = 7'(cnt);
        i_wr_buf_Bytecnt = 6'(byt); i_wr_frame_down = fd;
        tick();
        i_wr_req = 1'b0;
        if (modeled) model_add(rank, cnt, byt, fd);
        $display("req rank=%0d cnt=%0d bytes=%0d frame_down=%0d modeled=%0d", rank, cnt, byt, fd, modeled);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin tick(); n++; end
        if (o_busy) chk("idle_timeout", o_busy, 1'b0);
        tick(); tick();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int base, n;
        logic [27:0] held;
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
        tick(); tick(); tick();
        i_rst = 1'b0;
        chk("rst_cmd_en", o_app_cmd_en, 1'b0);
        chk("rst_wren", o_app_wdf_wren, 1'b0);
        chk("rst_addr", o_app_addr, F0);
        chk("rst_cea", o_dpb_rd_b_cea, 1'b1);
        chk("rst_busy_ovf_done", {o_busy, o_overflow, o_frame_done}, 3'b000);
        chk("rst_frame_len", o_frame_len, 24'd0);

        // Five requests before calibration: the fifth is dropped.
        for (int i = 0; i < 5; i++)
            push_req(2'($urandom_range(0, 3)), $urandom_range(0, 6), $urandom_range(0, 63),
                     1'($urandom_range(0, 1)), i < 4);
        chk("overflow_set", o_overflow, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        chk("precal_busy", o_busy, 1'b1);
        i_init_calib_complete = 1'b1;
        wait_idle(2000);
        chk("overflow_sticky", o_overflow, 1'b1);
        do_reset();
        chk("overflow_cleared", o_overflow, 1'b0);

        // Single full rank with an always-ready controller.
        acc_times.delete();
        push_req(2'd1, 91, 0, 1'b0, 1'b1);
        wait_idle(2000);
        chk("full_rank_beats", acc_times.size(), 91);
        if (acc_times.size() == 91) chk("beat_spacing", acc_times[90] - acc_times[0], 450);

        // Tail rank closes the frame: 1456 + 4*16 + 3 bytes in slot 0.
        push_req(2'd3, 5, 3, 1'b1, 1'b1);
        wait_idle(500);
        chk("tail_frame_len", o_frame_len, 24'd1523);
        chk("tail_frame_slot", o_frame_slot, 1'b0);
        chk("next_frame_base", o_app_addr, F1);

        // Backpressure on the third beat.
        base = accepts;
        push_req(2'd2, 6, 0, 1'b0, 1'b1);
        n = 0;
        while (accepts < base + 2 && n < 200) begin tick(); n++; end
        i_app_wdf_rdy = 1'b0;
        n = 0;
        while (!o_app_cmd_en && n < 50) begin tick(); n++; end
        chk("bp_issue_reached", o_app_cmd_en, 1'b1);
        held = o_app_addr;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("bp_hold_en", {o_app_cmd_en, o_app_wdf_wren}, 2'b11);
            chk("bp_hold_addr", o_app_addr, held);
        end
        chk("bp_no_accept", accepts, base + 2);
        i_app_wdf_rdy = 1'b1;
        wait_idle(500);
        chk("bp_total_accepts", accepts, base + 6);

        // Empty rank ending a frame: no command, length is the 96 bytes already queued.
        base = accepts;
        push_req(2'd0, 0, 0, 1'b1, 1'b1);
        wait_idle(200);
        chk("empty_no_cmd", accepts, base);
        chk("empty_frame_len", o_frame_len, 24'd96);
        chk("empty_frame_slot", o_frame_slot, 1'b1);
        chk("slot0_base_again", o_app_addr, F0);

        // Randomized groups with random controller backpressure.
        bp_rand = 1'b1;
        for (int g = 0; g < 8; g++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                push_req(2'($urandom_range(0, 3)), $urandom_range(0, 12), $urandom_range(0, 63),
                         1'($urandom_range(0, 1)), 1'b1);
            wait_idle(4000);
        end
        bp_rand = 1'b0;
        i_app_rdy = 1'b1; i_app_wdf_rdy = 1'b1;

        // Reset while a beat is stuck in issue, with more ranks still queued.
        i_app_rdy = 1'b0;
        push_req(2'd3, 4, 0, 1'b1, 1'b0);
        push_req(2'd1, 2, 5, 1'b1, 1'b0);
        n = 0;
        while (!o_app_cmd_en && n < 50) begin tick(); n++; end
        chk("rst_mid_issue", o_app_cmd_en, 1'b1);
        do_reset();
        chk("rst_mid_en", {o_app_cmd_en, o_app_wdf_wren}, 2'b00);
        chk("rst_mid_busy", o_busy, 1'b0);
        chk("rst_mid_addr", o_app_addr, F0);
        chk("rst_mid_done", o_frame_done, 1'b0);
        i_app_rdy = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        push_req(2'd0, 2, 7, 1'b1, 1'b1);
        wait_idle(200);
        chk("post_rst_frame_len", o_frame_len, 24'd23);

        chk("beats_left", exp_addr_q.size(), 0);
        chk("frames_left", exp_len_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
